// File: rtl/fb_rect_writer.sv
// Rectangle fill engine for a square frame buffer with a stride of 2^LINE_LOG2 pixels.
// The rectangle is clipped at the right and bottom edges, then written one pixel per accepted cycle in raster order.
module fb_rect_writer #(
  parameter int LINE_LOG2 = 6,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LINE_LOG2-1:0] x0,
  input  logic [LINE_LOG2-1:0] y0,
  input  logic [LINE_LOG2:0]   w,
  input  logic [LINE_LOG2:0]   h,
  input  logic [DATA_W-1:0]    color,
  input  logic                 wr_ready,
  output logic                 we,
  output logic [ADDR_W-1:0]    waddr,
  output logic [DATA_W-1:0]    wdata,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [LINE_LOG2:0] LINE_N = {1'b1, {LINE_LOG2{1'b0}}};

  state_t                 state_q, state_d;
  logic [LINE_LOG2-1:0]   col_q, col_d, row_q, row_d;
  logic [LINE_LOG2-1:0]   x0_q, x0_d, xe_q, xe_d, ye_q, ye_d;
  logic [DATA_W-1:0]      color_q, color_d;
  logic                   we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0]      waddr_q, waddr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;

  logic [LINE_LOG2:0]     rem_x_s, rem_y_s, ew_s, eh_s;

  // Clip extents against the remaining room to the right/bottom edge (7-bit compare, no wrap).
  always_comb begin
    rem_x_s = LINE_N - {1'b0, x0};
    rem_y_s = LINE_N - {1'b0, y0};
    ew_s    = (w < rem_x_s) ? w : rem_x_s;
    eh_s    = (h < rem_y_s) ? h : rem_y_s;
  end

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    x0_d    = x0_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    color_d = color_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x0_d    = x0;
          color_d = color;
          col_d   = x0;
          row_d   = y0;
          // Inclusive last column/row; only meaningful when the extent is non-zero.
          xe_d    = x0 + ew_s[LINE_LOG2-1:0] - {{(LINE_LOG2-1){1'b0}}, 1'b1};
          ye_d    = y0 + eh_s[LINE_LOG2-1:0] - {{(LINE_LOG2-1){1'b0}}, 1'b1};
          if ((ew_s == '0) || (eh_s == '0)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (wr_ready) begin
          if (col_q == xe_q) begin
            if (row_q == ye_q) begin
              state_d = DONE;
            end else begin
              col_d = x0_q;
              row_d = row_q + {{(LINE_LOG2-1){1'b0}}, 1'b1};
            end
          end else begin
            col_d = col_q + {{(LINE_LOG2-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    we_d    = (state_d == RUN);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    if (state_d == RUN) begin
      waddr_d = ADDR_W'({row_d, col_d});
      wdata_d = color_d;
    end else begin
      waddr_d = waddr_q;
      wdata_d = wdata_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      x0_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      color_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      x0_q    <= x0_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      color_q <= color_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
